// File: rtl/fetch_queue_pkg.sv
// Shared processor definitions: fetch FSM state encoding and fetch address defaults.
package fetch_queue_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fq_state_t;

    localparam int unsigned DEFAULT_PC_STEP  = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue_inst_fifo.sv
// Instruction buffer: DEPTH entries of {pc, instruction}; head visible with zero latency.
// No internal backpressure; the caller guarantees no push when full. Flush beats push/pop.
module inst_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [N-1:0]               push_dat,
    input  logic [N-1:0]               push_pc,
    input  logic                       pop,
    output logic [N-1:0]               head_dat,
    output logic [N-1:0]               head_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [N-1:0] pc;
        logic [N-1:0] dat;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is intentionally left unreset; only occupancy state is cleared.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= '{pc: push_pc, dat: push_dat};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr].dat;
    assign head_pc  = mem[rd_ptr].pc;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues reads, buffers responses (1-cycle memory latency).
// Requests are credit-limited by buffer occupancy plus in-flight read; redirect flushes.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          N        = 32,
    parameter int          DEPTH    = 4,
    parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC),
    parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   halt_i,
    input  logic                   redirect_i,
    input  logic [N-1:0]           redirect_pc_i,
    output logic                   mem_req_o,
    output logic [N-1:0]           mem_addr_o,
    input  logic [N-1:0]           mem_data_i,
    output logic                   inst_valid_o,
    input  logic                   inst_ready_i,
    output logic [N-1:0]           inst_o,
    output logic [N-1:0]           inst_pc_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    fq_state_t      state;
    fq_state_t      state_nxt;
    logic [N-1:0]   fetch_pc;
    logic [N-1:0]   issued_pc;
    logic           inflight;
    logic [CW:0]    occupancy;
    logic           credit_ok;
    logic           push;
    logic           pop;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= ST_BOOT;
        else      state <= state_nxt;
    end

    // Redirect deliberately has no effect on the state; it only steers the PC.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT:  state_nxt = ST_FETCH;
            ST_FETCH: if (halt_i)  state_nxt = ST_HALT;
            ST_HALT:  if (!halt_i) state_nxt = ST_FETCH;
            default:  state_nxt = ST_BOOT;
        endcase
    end

    // An in-flight read already owns a slot, so it counts against the credit.
    assign occupancy = {1'b0, count_o} + (CW + 1)'(inflight);
    assign credit_ok = occupancy < (CW + 1)'(DEPTH);
    assign mem_req_o = (state == ST_FETCH) && !redirect_i && credit_ok;
    assign mem_addr_o = fetch_pc;

    assign inst_valid_o = (count_o != '0);
    assign push = inflight && !redirect_i;
    assign pop  = inst_valid_o && inst_ready_i && !redirect_i;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= mem_req_o;
            if (mem_req_o) issued_pc <= fetch_pc;
            if (redirect_i)     fetch_pc <= redirect_pc_i;
            else if (mem_req_o) fetch_pc <= fetch_pc + N'(PC_STEP);
        end
    end

    inst_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk      (CLK),
        .rst_n    (RST),
        .flush    (redirect_i),
        .push     (push),
        .push_dat (mem_data_i),
        .push_pc  (issued_pc),
        .pop      (pop),
        .head_dat (inst_o),
        .head_pc  (inst_pc_o),
        .count    (count_o)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios then random traffic against a queue model.
module tb_fetch_queue;

    localparam int N       = 32;
    localparam int DEPTH   = 4;
    localparam int PC_STEP = 4;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic                   halt_i;
    logic                   redirect_i;
    logic [N-1:0]           redirect_pc_i;
    logic                   mem_req_o;
    logic [N-1:0]           mem_addr_o;
    logic [N-1:0]           mem_data_i;
    logic                   inst_valid_o;
    logic                   inst_ready_i;
    logic [N-1:0]           inst_o;
    logic [N-1:0]           inst_pc_o;
    logic [$clog2(DEPTH):0] count_o;

    fetch_queue #(.N(N), .DEPTH(DEPTH), .RESET_PC('0), .PC_STEP(PC_STEP)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .halt_i        (halt_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_i    (mem_data_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .count_o       (count_o)
    );

    always #5 CLK = ~CLK;

    // Reference model: cycles since reset, last halt level, pending read, fetch PC, buffer contents.
    int          cyc;
    bit          prev_halt;
    bit          pend;
    logic [31:0] pend_addr;
    logic [31:0] m_pc;
    logic [31:0] key;
    logic [63:0] q[$];

    int          n_cmp = 0;
    int          n_bad = 0;

    logic        last_valid;
    logic        last_req;
    logic [31:0] last_addr;
    logic [31:0] last_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_in_fetch();
        return (cyc == 1) || (cyc >= 2 && !prev_halt);
    endfunction

    task automatic model_reset();
        cyc = 0;
        prev_halt = 0;
        pend = 0;
        pend_addr = '0;
        m_pc = '0;
        q.delete();
    endtask

    task automatic cycle(input bit h, input bit r, input logic [31:0] rpc, input bit rdy);
        bit          exp_req;
        logic [63:0] head;
        @(negedge CLK);
        halt_i        = h;
        redirect_i    = r;
        redirect_pc_i = rpc;
        inst_ready_i  = rdy;
        mem_data_i    = pend ? (pend_addr ^ key) : $urandom();
        #1;
        exp_req = m_in_fetch() && !r && (q.size() + int'(pend) < DEPTH);
        check("mem_req", 64'(mem_req_o), 64'(exp_req));
        if (exp_req) check("mem_addr", 64'(mem_addr_o), 64'(m_pc));
        check("count", 64'(count_o), 64'(q.size()));
        check("inst_valid", 64'(inst_valid_o), 64'(q.size() != 0));
        if (q.size() != 0) begin
            head = q[0];
            check("inst_pc", 64'(inst_pc_o), 64'(head[63:32]));
            check("inst", 64'(inst_o), 64'(head[31:0]));
        end
        last_valid = inst_valid_o;
        last_req   = mem_req_o;
        last_addr  = mem_addr_o;
        last_count = 32'(count_o);
        if (cyc < 1000) cyc++;
        prev_halt = h;
        if (r) begin
            q.delete();
            pend = 0;
            m_pc = rpc;
        end else begin
            if (rdy && q.size() != 0) void'(q.pop_front());
            if (pend) q.push_back({pend_addr, pend_addr ^ key});
            pend      = exp_req;
            pend_addr = m_pc;
            if (exp_req) m_pc = m_pc + PC_STEP;
        end
    endtask

    // Asserts reset between edges, checks outputs react at once, releases just after a rising edge.
    task automatic do_reset();
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        check("rst_mem_req", 64'(mem_req_o), 64'(0));
        check("rst_valid", 64'(inst_valid_o), 64'(0));
        check("rst_count", 64'(count_o), 64'(0));
        model_reset();
        @(posedge CLK);
        #2 RST = 1'b1;
    endtask

    initial begin
        int first_v;
        RST           = 1'b1;
        halt_i        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        inst_ready_i  = 1'b0;
        mem_data_i    = '0;
        key           = '0;
        model_reset();
        do_reset();

        // Streaming with data = address; first valid three cycles after release.
        first_v = -1;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, '0, 1);
            if (last_valid && first_v < 0) first_v = i;
        end
        check("first_valid_cycle", 64'(first_v), 64'(3));

        // Stall decode: buffer fills and requests stop.
        for (int i = 0; i < 8; i++) cycle(0, 0, '0, 0);
        check("full_count", 64'(last_count), 64'(DEPTH));
        check("full_no_req", 64'(last_req), 64'(0));

        // One pop opens a credit, a read goes in flight, then redirect.
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 0);
        cycle(0, 1, 32'h100, 0);
        cycle(0, 0, '0, 0);
        check("redir_count", 64'(last_count), 64'(0));
        check("redir_req", 64'(last_req), 64'(1));
        check("redir_addr", 64'(last_addr), 64'(32'h100));
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1);

        // Halt for five cycles, then resume.
        for (int i = 0; i < 5; i++) cycle(1, 0, '0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1);

        // PC wrap at the top of the address space.
        cycle(0, 1, 32'hFFFF_FFFC, 1);
        cycle(0, 0, '0, 1);
        check("wrap_addr0", 64'(last_addr), 64'(32'hFFFF_FFFC));
        cycle(0, 0, '0, 1);
        check("wrap_addr1", 64'(last_addr), 64'(32'h0000_0000));
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1);

        // Random traffic with scrambled memory data.
        key = $urandom();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 5),
                  $urandom() & 32'hFFFF_FFFC, ($urandom_range(0, 99) < 60));
        end

        // Reset mid-stream, then restart from the reset PC.
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 0);
        do_reset();
        key = '0;
        for (int i = 0; i < 8; i++) cycle(0, 0, '0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
